// File: rtl/conv_window_feeder_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window feeder.
// master is the feeder side; slave is the pixel source plus window consumer.
interface conv_window_feeder_if #(
    parameter int IN_WIDTH = 5,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [IN_WIDTH-1:0]   in_pixel;
    logic                  in_valid;
    logic                  in_ready;
    logic [9*IN_WIDTH-1:0] out_window;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         out_row;
    logic [CW-1:0]         out_col;
    logic                  out_last;

    modport master (
        input  in_pixel,
        input  in_valid,
        output in_ready,
        output out_window,
        output out_valid,
        input  out_ready,
        output out_row,
        output out_col,
        output out_last
    );

    modport slave (
        output in_pixel,
        output in_valid,
        input  in_ready,
        input  out_window,
        input  out_valid,
        output out_ready,
        input  out_row,
        input  out_col,
        input  out_last
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to sliding 3x3 windows (stride 1, no padding).
// Two line buffers hold the previous rows; one output stage, full throughput.
module conv_window_feeder #(
    parameter int IN_WIDTH = 5,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
) (
    input logic clk,
    input logic rst,
    conv_window_feeder_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [IN_WIDTH-1:0] lb0 [IMG_W];
    logic [IN_WIDTH-1:0] lb1 [IMG_W];
    logic [IN_WIDTH-1:0] win [3][3];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          valid_q;
    logic          last_q;

    logic ready;
    logic accept;
    logic emit;
    logic col_end;
    logic row_end;
    logic [9*IN_WIDTH-1:0] flat;

    assign ready   = !(valid_q && !bus.out_ready);
    assign accept  = bus.in_valid && ready;
    assign col_end = (col == COL_MAX);
    assign row_end = (row == ROW_MAX);
    assign emit    = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Data path carries no reset; the window is only exposed while valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= bus.in_pixel;
            lb1[col]  <= lb0[col];
            lb0[col]  <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (emit) begin
                valid_q <= 1'b1;
                last_q  <= row_end && col_end;
                row_q   <= row - RW'(2);
                col_q   <= col - CW'(2);
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        flat = '0;
        if (valid_q) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    flat[(r*3+c)*IN_WIDTH +: IN_WIDTH] = win[r][c];
                end
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_window = flat;
    assign bus.out_valid  = valid_q;
    assign bus.out_row    = row_q;
    assign bus.out_col    = col_q;
    assign bus.out_last   = last_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 5x5 image.
// Expected windows come from a 3x3 slice of the generated frame.
module tb_conv_window_feeder;
    localparam int IW = 5;
    localparam int W  = 5;
    localparam int H  = 5;

    typedef struct {
        logic [9*IW-1:0] win;
        int              row;
        int              col;
        bit              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    conv_window_feeder_if #(.IN_WIDTH(IW), .IMG_W(W), .IMG_H(H)) bus ();

    conv_window_feeder #(.IN_WIDTH(IW), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    logic [9*IW-1:0] wlog[$];
    int lrow[$];
    int lcol[$];
    int last_cnt = 0;
    int bp_cnt = 0;
    int rdy_mode = 0;
    int bp_left = 0;
    bit bp_done = 0;
    bit lat_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] pix(input int kind, input int idx);
        return (kind == 0) ? IW'(idx % 32) : IW'(31 - idx);
    endfunction

    function automatic logic [9*IW-1:0] mk(input int kind, input int r,
                                           input int c);
        logic [9*IW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*IW +: IW] = pix(kind, (r+i)*W + c + j);
        return w;
    endfunction

    // Consumer side: scoreboard, hold stability and backpressure checks.
    bit              hold_prev = 0;
    logic [9*IW-1:0] h_win;
    logic [2:0]      h_row;
    logic [2:0]      h_col;
    always @(negedge clk) begin
        exp_t e;
        if (hold_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_win", bus.out_window, h_win);
            chk("hold_row", bus.out_row, h_row);
            chk("hold_col", bus.out_col, h_col);
        end
        if (bus.out_valid && !bus.out_ready) begin
            bp_cnt++;
            chk("in_ready_bp", bus.in_ready, 0);
        end
        if (!bus.out_valid && !rst)
            chk("in_ready_idle", bus.in_ready, 1);
        hold_prev = bus.out_valid && !bus.out_ready && !rst;
        h_win = bus.out_window;
        h_row = bus.out_row;
        h_col = bus.out_col;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_win", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("win", bus.out_window, e.win);
                chk("row", bus.out_row, e.row);
                chk("col", bus.out_col, e.col);
                chk("last", bus.out_last, e.last);
            end
            wlog.push_back(bus.out_window);
            lrow.push_back(int'(bus.out_row));
            lcol.push_back(int'(bus.out_col));
            if (bus.out_last) last_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bp_left > 0) begin
                    bus.out_ready = 1'b0;
                    bp_left--;
                end else if (!bp_done && bus.out_valid && wlog.size() == 3) begin
                    bus.out_ready = 1'b0;
                    bp_left = 3;
                    bp_done = 1;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic send_frame(input int kind, input int npix, input int gap);
        exp_t e;
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                if ((r+2)*W + c + 2 < npix) begin
                    e.win  = mk(kind, r, c);
                    e.row  = r;
                    e.col  = c;
                    e.last = (r == H-3) && (c == W-3);
                    exp_q.push_back(e);
                end
            end
        end
        for (int i = 0; i < npix; i++) begin
            bit acc;
            int budget;
            acc = 0;
            budget = 0;
            bus.in_pixel = pix(kind, i);
            while (!acc) begin
                bus.in_valid = ($urandom_range(0, 99) >= gap);
                @(negedge clk);
                if (lat_chk && i == 12) chk("pre_lat", bus.out_valid, 0);
                if (lat_chk && i == 13) chk("lat", bus.out_valid, 1);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 200) begin
                    chk("in_stall", 1, 0);
                    acc = 1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic new_test();
        wlog.delete();
        lrow.delete();
        lcol.delete();
        last_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_row", bus.out_row, 0);
        chk("rst_col", bus.out_col, 0);
        chk("rst_win", bus.out_window, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Gap-free frame, consumer always ready
        new_test();
        lat_chk = 1;
        send_frame(0, 25, 0);
        lat_chk = 0;
        drain();
        chk("t1_count", wlog.size(), 9);
        chk("t1_first", wlog[0],
            {5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd2, 5'd1, 5'd0});
        chk("t1_first_rc", {lrow[0], lcol[0]}, 0);
        chk("t1_final", wlog[8],
            {5'd24, 5'd23, 5'd22, 5'd19, 5'd18, 5'd17, 5'd14, 5'd13, 5'd12});
        chk("t1_final_row", lrow[8], 2);
        chk("t1_final_col", lcol[8], 2);
        chk("t1_last_cnt", last_cnt, 1);

        // Four-cycle backpressure stall on the fourth window
        new_test();
        bp_cnt = 0;
        bp_done = 0;
        rdy_mode = 2;
        send_frame(0, 25, 0);
        drain();
        rdy_mode = 0;
        chk("bp_count", wlog.size(), 9);
        chk("bp_done", bp_done, 1);
        chk("bp_cycles", bp_cnt, 4);
        chk("bp_last_cnt", last_cnt, 1);

        // Random input gaps and random consumer readiness
        new_test();
        rdy_mode = 1;
        send_frame(0, 25, 50);
        send_frame(1, 25, 50);
        drain();
        rdy_mode = 0;
        chk("rnd_count", wlog.size(), 18);
        chk("rnd_last_cnt", last_cnt, 2);

        // Back-to-back frames with different patterns
        new_test();
        send_frame(0, 25, 0);
        send_frame(1, 25, 0);
        drain();
        chk("b2b_count", wlog.size(), 18);
        chk("b2b_f2_first", wlog[9],
            {5'd19, 5'd20, 5'd21, 5'd24, 5'd25, 5'd26, 5'd29, 5'd30, 5'd31});
        chk("b2b_f2_rc", {lrow[9], lcol[9]}, 0);
        chk("b2b_last_cnt", last_cnt, 2);

        // Reset after the first window of a frame
        new_test();
        send_frame(0, 13, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_rc", {bus.out_row, bus.out_col}, 0);
        @(posedge clk);
        #1;
        send_frame(0, 25, 0);
        drain();
        chk("rst_mid_count", wlog.size(), 10);
        chk("rst_mid_first", wlog[1],
            {5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd2, 5'd1, 5'd0});
        chk("rst_mid_rc0", {lrow[1], lcol[1]}, 0);
        chk("rst_mid_last_cnt", last_cnt, 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
